// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM between a write port and a read port.
// Each grant runs one fixed-length access; all SRAM pins are driven from registers.
module sram_arbiter #(
    parameter int unsigned ADDR_W        = 20,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_ack,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    inout  wire  [DATA_W-1:0] io_sram_dq,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_ce,
    output logic              o_sram_oe,
    output logic              o_sram_we,
    output logic              o_sram_lb,
    output logic              o_sram_ub
);

    localparam logic [3:0] LP_LAST = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_last_wr, w_last_wr_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic r_ce, r_oe, r_we, r_be, r_dq_oe;
    logic w_ce_nxt, w_oe_nxt, w_we_nxt, w_be_nxt, w_dq_oe_nxt;

    logic w_last_cyc;
    logic w_grant_wr;
    logic w_grant_rd;
    logic w_rd_capture;

    assign w_last_cyc = (r_cnt == LP_LAST);

    // On a tie the port that did not win last time gets the bus.
    assign w_grant_wr = i_wr_req && (!i_rd_req || !r_last_wr);
    assign w_grant_rd = i_rd_req && (!i_wr_req || r_last_wr);

    // State register, including the pin registers so reset idles the bus asynchronously.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_last_wr <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ce      <= 1'b1;
            r_oe      <= 1'b1;
            r_we      <= 1'b1;
            r_be      <= 1'b1;
            r_dq_oe   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last_wr <= w_last_wr_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_ce      <= w_ce_nxt;
            r_oe      <= w_oe_nxt;
            r_we      <= w_we_nxt;
            r_be      <= w_be_nxt;
            r_dq_oe   <= w_dq_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_wr_nxt = r_last_wr;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (w_grant_wr) begin
                    w_state_nxt   = S_WRITE;
                    w_last_wr_nxt = 1'b1;
                    w_addr_nxt    = i_wr_addr;
                    w_wdata_nxt   = i_wr_data;
                end else if (w_grant_rd) begin
                    w_state_nxt   = S_READ;
                    w_last_wr_nxt = 1'b0;
                    w_addr_nxt    = i_rd_addr;
                end
            end
            S_WRITE, S_READ: begin
                if (w_last_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Pin values are decoded from the next state so they line up with the registered state.
    always_comb begin
        w_ce_nxt    = 1'b1;
        w_oe_nxt    = 1'b1;
        w_we_nxt    = 1'b1;
        w_be_nxt    = 1'b1;
        w_dq_oe_nxt = 1'b0;
        unique case (w_state_nxt)
            S_WRITE: begin
                w_ce_nxt    = 1'b0;
                w_we_nxt    = 1'b0;
                w_be_nxt    = 1'b0;
                w_dq_oe_nxt = 1'b1;
            end
            S_READ: begin
                w_ce_nxt = 1'b0;
                w_oe_nxt = 1'b0;
                w_be_nxt = 1'b0;
            end
            default: begin
                w_ce_nxt = 1'b1;
            end
        endcase
    end

    assign w_rd_capture = (r_state == S_READ) && w_last_cyc;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_capture;
            if (w_rd_capture) begin
                r_rd_data <= io_sram_dq;
            end
        end
    end

    assign o_wr_ack    = (r_state == S_WRITE) && w_last_cyc;
    assign o_rd_ack    = w_rd_capture;
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_sram_addr = r_addr;
    assign o_sram_ce   = r_ce;
    assign o_sram_oe   = r_oe;
    assign o_sram_we   = r_we;
    assign o_sram_lb   = r_be;
    assign o_sram_ub   = r_be;
    assign io_sram_dq  = r_dq_oe ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM model on the DQ bus.
module tb_sram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        rd_valid;
    wire  [15:0] sram_dq;
    logic [19:0] sram_addr;
    logic        sram_ce;
    logic        sram_oe;
    logic        sram_we;
    logic        sram_lb;
    logic        sram_ub;

    int n_checks;
    int n_errors;

    logic [15:0] mem [0:255];
    logic        model_ovr;
    logic [15:0] model_ovr_data;

    sram_arbiter #(
        .ADDR_W       (20),
        .DATA_W       (16),
        .ACCESS_CYCLES(2)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_wr_req   (wr_req),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_wr_ack   (wr_ack),
        .i_rd_req   (rd_req),
        .i_rd_addr  (rd_addr),
        .o_rd_ack   (rd_ack),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .io_sram_dq (sram_dq),
        .o_sram_addr(sram_addr),
        .o_sram_ce  (sram_ce),
        .o_sram_oe  (sram_oe),
        .o_sram_we  (sram_we),
        .o_sram_lb  (sram_lb),
        .o_sram_ub  (sram_ub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: drives the bus only while the chip is read-enabled.
    assign sram_dq = (!sram_ce && !sram_oe && sram_we)
                     ? (model_ovr ? model_ovr_data : mem[sram_addr[7:0]]) : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_ce && !sram_we) mem[sram_addr[7:0]] <= sram_dq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_req  = 1'($urandom);
        rd_req  = 1'($urandom);
        wr_addr = 20'($urandom);
        wr_data = 16'($urandom);
        rd_addr = 20'($urandom);
        #3;
        tick();
        tick();
        n_checks++;
        if ({sram_ce, sram_oe, sram_we, sram_lb, sram_ub} !== 5'b11111) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 11111",
                     {sram_ce, sram_oe, sram_we, sram_lb, sram_ub});
        end
        n_checks++;
        if ({wr_ack, rd_ack, rd_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_acks: got %b want 000", {wr_ack, rd_ack, rd_valid});
        end
        n_checks++;
        if (rd_data !== 16'h0000 || sram_addr !== 20'h00000) begin
            n_errors++;
            $display("FAIL reset_data_addr: got %h/%h want 0000/00000", rd_data, sram_addr);
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_write();
        wr_req  = 1'b1;
        wr_addr = 20'h00010;
        wr_data = 16'hA5A5;
        tick();
        n_checks++;
        if ({sram_ce, sram_oe, sram_we, sram_lb, sram_ub} !== 5'b01000 || wr_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL write_c0: got ctrl %b ack %b want 01000 ack 0",
                     {sram_ce, sram_oe, sram_we, sram_lb, sram_ub}, wr_ack);
        end
        n_checks++;
        if (sram_addr !== 20'h00010 || sram_dq !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL write_bus: got addr %h dq %h want 00010 A5A5", sram_addr, sram_dq);
        end
        tick();
        n_checks++;
        if ({sram_ce, sram_we} !== 2'b00 || wr_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL write_c1: got ce/we %b ack %b want 00 ack 1", {sram_ce, sram_we}, wr_ack);
        end
        wr_req = 1'b0;
        tick();
        n_checks++;
        if ({sram_ce, sram_oe, sram_we, sram_lb, sram_ub} !== 5'b11111 || wr_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL write_idle: got ctrl %b ack %b want 11111 ack 0",
                     {sram_ce, sram_oe, sram_we, sram_lb, sram_ub}, wr_ack);
        end
        n_checks++;
        if (sram_addr !== 20'h00010 || sram_dq === 16'hA5A5 || mem[8'h10] !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL write_after: got addr %h dq %h mem %h want 00010, not A5A5, A5A5",
                     sram_addr, sram_dq, mem[8'h10]);
        end
    endtask

    task automatic test_read();
        model_ovr      = 1'b1;
        model_ovr_data = 16'hBEEF;
        rd_req         = 1'b1;
        rd_addr        = 20'h00010;
        tick();
        n_checks++;
        if ({sram_ce, sram_oe, sram_we, sram_lb, sram_ub} !== 5'b00100 || rd_ack !== 1'b0) begin
            n_errors++;
            $display("FAIL read_c0: got ctrl %b ack %b want 00100 ack 0",
                     {sram_ce, sram_oe, sram_we, sram_lb, sram_ub}, rd_ack);
        end
        tick();
        n_checks++;
        if (sram_oe !== 1'b0 || rd_ack !== 1'b1 || rd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL read_c1: got oe %b ack %b valid %b want 0 1 0", sram_oe, rd_ack, rd_valid);
        end
        rd_req = 1'b0;
        tick();
        n_checks++;
        if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF || sram_oe !== 1'b1) begin
            n_errors++;
            $display("FAIL read_valid: got valid %b data %h oe %b want 1 BEEF 1",
                     rd_valid, rd_data, sram_oe);
        end
        tick();
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL read_hold: got valid %b data %h want 0 BEEF", rd_valid, rd_data);
        end
        model_ovr = 1'b0;
    endtask

    task automatic test_saturated();
        rst_n   = 1'b0;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_addr = 20'h00020;
        wr_data = 16'h1234;
        rd_addr = 20'h00020;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_checks++;
            if ({wr_ack, rd_ack} !== {1'(k % 6 == 2), 1'(k % 6 == 5)}) begin
                n_errors++;
                $display("FAIL sat_ack[%0d]: got wr/rd %b want %b", k, {wr_ack, rd_ack},
                         {1'(k % 6 == 2), 1'(k % 6 == 5)});
            end
            if (sram_oe == 1'b0) begin
                n_checks++;
                if (sram_we !== 1'b1) begin
                    n_errors++;
                    $display("FAIL sat_rd_we[%0d]: got we %b want 1", k, sram_we);
                end
            end
            if (k % 6 == 0) begin
                n_checks++;
                if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
                    n_errors++;
                    $display("FAIL sat_rdata[%0d]: got valid %b data %h want 1 1234",
                             k, rd_valid, rd_data);
                end
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_write_stream();
        int idx;
        idx     = 0;
        wr_req  = 1'b1;
        wr_addr = 20'h00000;
        wr_data = 16'hC000;
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_checks++;
            if (wr_ack !== 1'((k % 3 == 2) && (k <= 11))) begin
                n_errors++;
                $display("FAIL stream_ack[%0d]: got %b want %b", k, wr_ack,
                         1'((k % 3 == 2) && (k <= 11)));
            end
            if (wr_ack === 1'b1) begin
                idx++;
                wr_addr = 20'(idx);
                wr_data = 16'hC000 + 16'(idx);
                if (idx == 4) wr_req = 1'b0;
            end
        end
        for (int a = 0; a < 4; a++) begin
            n_checks++;
            if (mem[a] !== 16'hC000 + 16'(a)) begin
                n_errors++;
                $display("FAIL stream_mem[%0d]: got %h want %h", a, mem[a], 16'hC000 + 16'(a));
            end
        end
    endtask

    task automatic test_reset_mid_write();
        wr_req  = 1'b1;
        wr_addr = 20'h00040;
        wr_data = 16'h5555;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sram_ce, sram_we} !== 2'b11 || wr_ack !== 1'b0 || sram_dq === 16'h5555) begin
            n_errors++;
            $display("FAIL rstmid_async: got ce/we %b ack %b dq %h want 11 0 not-5555",
                     {sram_ce, sram_we}, wr_ack, sram_dq);
        end
        tick();
        n_checks++;
        if (wr_ack !== 1'b0 || sram_ce !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_hold: got ack %b ce %b want 0 1", wr_ack, sram_ce);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({sram_ce, sram_we} !== 2'b00 || sram_addr !== 20'h00040 || sram_dq !== 16'h5555) begin
            n_errors++;
            $display("FAIL rstmid_regrant: got ce/we %b addr %h dq %h want 00 00040 5555",
                     {sram_ce, sram_we}, sram_addr, sram_dq);
        end
        tick();
        n_checks++;
        if (wr_ack !== 1'b1) begin
            n_errors++;
            $display("FAIL rstmid_ack: got %b want 1", wr_ack);
        end
        wr_req = 1'b0;
        tick();
        n_checks++;
        if (mem[8'h40] !== 16'h5555) begin
            n_errors++;
            $display("FAIL rstmid_mem: got %h want 5555", mem[8'h40]);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        model_ovr      = 1'b0;
        model_ovr_data = 16'h0000;
        rst_n          = 1'b1;
        wr_req         = 1'b0;
        rd_req         = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        rd_addr        = '0;
        test_reset();
        test_write();
        test_read();
        test_saturated();
        test_write_stream();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
